// File: rtl/pulp_clock_sel_ctrl.sv
// Glitch-free clock source switch sequencer: gate, flip select, settle, ungate, ack.
// Optional lock-wait stage with timeout when CLK_SW_LOCK_WAIT_EN is defined.
module pulp_clock_sel_ctrl #(
   parameter int CNT_W          = 8,
   parameter int OFF_CYCLES     = 4,
   parameter int SETTLE_CYCLES  = 8,
   parameter int ON_CYCLES      = 2,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_i,
   input  logic sel_i,
   output logic ack_o,
   output logic busy_o,
   output logic clk_sel_o,
`ifdef CLK_SW_LOCK_WAIT_EN
   input  logic lock_i,
   output logic err_o,
`endif
   output logic clk_en_o
);

   localparam int CMAX = (2 ** CNT_W) - 1;

   if (OFF_CYCLES < 1 || OFF_CYCLES > CMAX ||
       SETTLE_CYCLES < 1 || SETTLE_CYCLES > CMAX ||
       ON_CYCLES < 1 || ON_CYCLES > CMAX ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > CMAX) begin : g_bad_param
      $error("pulp_clock_sel_ctrl: cycle parameter out of range");
   end

   localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYCLES - 1);
`ifdef CLK_SW_LOCK_WAIT_EN
   localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
`ifdef CLK_SW_LOCK_WAIT_EN
      LOCK,
`endif
      GATE_OFF,
      SWITCH,
      GATE_ON,
      ACK
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tgt_q, tgt_d;
   logic             sel_q, sel_d;
   logic             err_q, err_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tgt_q   <= 1'b0;
         sel_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      sel_d   = sel_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (req_i) begin
               tgt_d = sel_i;
               if (sel_i == sel_q) begin
                  state_d = ACK;
               end else begin
`ifdef CLK_SW_LOCK_WAIT_EN
                  state_d = LOCK;
                  cnt_d   = TO_LD;
`else
                  state_d = GATE_OFF;
                  cnt_d   = OFF_LD;
`endif
               end
            end
         end
`ifdef CLK_SW_LOCK_WAIT_EN
         LOCK: begin
            if (lock_i) begin
               state_d = GATE_OFF;
               cnt_d   = OFF_LD;
            end else if (cnt_q == '0) begin
               state_d = ACK;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         GATE_OFF: begin
            // select flips on the same edge that enters SWITCH, gate still closed
            if (cnt_q == '0) begin
               state_d = SWITCH;
               sel_d   = tgt_q;
               cnt_d   = SET_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SWITCH: begin
            if (cnt_q == '0) begin
               state_d = GATE_ON;
               cnt_d   = ON_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GATE_ON: begin
            if (cnt_q == '0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ack_o     = (state_q == ACK);
   assign busy_o    = (state_q != IDLE);
   assign clk_sel_o = sel_q;
   assign clk_en_o  = !((state_q == GATE_OFF) || (state_q == SWITCH));
`ifdef CLK_SW_LOCK_WAIT_EN
   assign err_o     = ack_o && err_q;
`endif

   a_sel_gated: assert property (@(posedge clk_i)
      (rst_ni && $past(rst_ni) && (clk_sel_o != $past(clk_sel_o)))
      |-> !clk_en_o)
      else $error("clk_sel_o changed while clock gate open");

endmodule

// File: tb/tb_pulp_clock_sel_ctrl.sv
// Scoreboard bench for pulp_clock_sel_ctrl: stimulus queues expected acks,
// a monitor pops and checks them whenever ack_o is seen.
module tb_pulp_clock_sel_ctrl;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic req_i = 1'b0;
   logic sel_i = 1'b0;
   logic ack_o, busy_o, clk_sel_o, clk_en_o;
`ifdef CLK_SW_LOCK_WAIT_EN
   logic lock_i = 1'b1;
   logic err_o;
   localparam int LK = 1;
`else
   localparam int LK = 0;
`endif

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int   cyc;
      logic sel;
      logic err;
   } exp_t;
   exp_t q[$];

   pulp_clock_sel_ctrl dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .sel_i    (sel_i),
      .ack_o    (ack_o),
      .busy_o   (busy_o),
      .clk_sel_o(clk_sel_o),
`ifdef CLK_SW_LOCK_WAIT_EN
      .lock_i   (lock_i),
      .err_o    (err_o),
`endif
      .clk_en_o (clk_en_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every ack must match the head of the expectation queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack_o === 1'b1) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ack: got ack at cyc %0d expected none", cyc);
            end else begin
               e = q.pop_front();
               chk("ack_cycle", cyc, e.cyc);
               chk("ack_sel", int'(clk_sel_o), int'(e.sel));
               chk("ack_busy", int'(busy_o), 1);
`ifdef CLK_SW_LOCK_WAIT_EN
               chk("ack_err", int'(err_o), int'(e.err));
`endif
            end
         end
      end
   end

   // drive a request that takes effect at the next rising edge; returns n
   task automatic issue(input logic s, output int n);
      @(negedge clk);
      req_i = 1'b1;
      sel_i = s;
      n = cyc;
   endtask

   task automatic full_switch(input logic s, input logic from);
      int n;
      issue(s, n);
      q.push_back('{cyc: n + 15 + LK, sel: s, err: 1'b0});
      for (int k = 1; k <= 15 + LK; k++) begin
         @(negedge clk);
         if (k == 1) req_i = 1'b0;
         chk("sw_en", int'(clk_en_o),
             (k >= 1 + LK && k <= 12 + LK) ? 0 : 1);
         chk("sw_sel", int'(clk_sel_o),
             (k >= 5 + LK) ? int'(s) : int'(from));
      end
   endtask

   initial begin
      int n;
      // 1: reset
      repeat (3) @(negedge clk);
      chk("rst_sel", int'(clk_sel_o), 0);
      chk("rst_en", int'(clk_en_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_ack", int'(ack_o), 0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      // 3: same-source request on clk0
      issue(1'b0, n);
      q.push_back('{cyc: n + 1, sel: 1'b0, err: 1'b0});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         req_i = 1'b0;
         chk("same0_en", int'(clk_en_o), 1);
      end

      // 2: switch 0->1
      full_switch(1'b1, 1'b0);
      repeat (2) @(negedge clk);

      // same-source request on clk1
      issue(1'b1, n);
      q.push_back('{cyc: n + 1, sel: 1'b1, err: 1'b0});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         req_i = 1'b0;
         chk("same1_en", int'(clk_en_o), 1);
      end

      // switch back 1->0
      full_switch(1'b0, 1'b1);
      repeat (2) @(negedge clk);

      // 4: busy request during SWITCH is ignored
      issue(1'b1, n);
      q.push_back('{cyc: n + 15 + LK, sel: 1'b1, err: 1'b0});
      for (int k = 1; k <= 18 + LK; k++) begin
         @(negedge clk);
         req_i = (k == 6 + LK);
         if (k == 6 + LK) sel_i = 1'b0;
      end
      chk("busy_final_sel", int'(clk_sel_o), 1);
      chk("busy_idle", int'(busy_o), 0);

      // 5: reset mid-sequence during SETTLE
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      issue(1'b1, n);
      for (int k = 1; k <= 7 + LK; k++) begin
         @(negedge clk);
         req_i = 1'b0;
      end
      chk("settle_sel", int'(clk_sel_o), 1);
      chk("settle_en", int'(clk_en_o), 0);
      rst_ni = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      chk("abort_sel", int'(clk_sel_o), 0);
      chk("abort_en", int'(clk_en_o), 1);
      chk("abort_ack", int'(ack_o), 0);
      chk("abort_busy", int'(busy_o), 0);
      repeat (20) @(negedge clk);
      chk("abort_idle_sel", int'(clk_sel_o), 0);

`ifdef CLK_SW_LOCK_WAIT_EN
      // 6: lock never arrives -> timeout with err
      lock_i = 1'b0;
      issue(1'b1, n);
      q.push_back('{cyc: n + 201, sel: 1'b0, err: 1'b1});
      for (int k = 1; k <= 201; k++) begin
         @(negedge clk);
         req_i = 1'b0;
         chk("to_en", int'(clk_en_o), 1);
         chk("to_sel", int'(clk_sel_o), 0);
      end
      lock_i = 1'b1;
`endif

      repeat (5) @(negedge clk);
      chk("pending_acks", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
